// File: rtl/ecc_apb_pkg.sv
// Shared types for the ECC APB requester: FSM state encoding and the queued
// command record carried through the command FIFO.
package ecc_apb_pkg;

  localparam int ADDR_W = 20;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    WAIT_DONE
  } state_e;

  typedef struct packed {
    logic              write;
    logic              wait_done;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ecc_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy; a pushed entry is only
// visible to the reader from the following cycle.
module ecc_cmd_fifo
  import ecc_apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  cmd_t                   wdata,
  output cmd_t                   rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ecc_apb_requester.sv
// APB initiator for the ECC encoder/decoder slave: drains queued register
// commands as SETUP/ACCESS pairs and optionally waits for operation_done.
module ecc_apb_requester
  import ecc_apb_pkg::*;
#(
  parameter int AMBA_ADDR_WIDTH = ADDR_W,
  parameter int AMBA_WORD       = WORD_W,
  parameter int FIFO_DEPTH      = 4,
  parameter int DONE_TIMEOUT    = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic                       cmd_wait_done,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       done_pulse,
  output logic                       timeout_err,
  input  logic                       err_clr,
  output logic                       busy,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done
);

  localparam int                CNT_W    = $clog2(DONE_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  state_e                      state;
  state_e                      next_state;
  cmd_t                        push_cmd;
  cmd_t                        head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        pop;
  logic                        leave;
  logic                        done_hit;
  logic                        timeout_hit;
  logic                        capture;
  logic                        cur_wait_done;
  logic [CNT_W-1:0]            wait_cnt;

  always_comb begin
    push_cmd.write     = cmd_write;
    push_cmd.wait_done = cmd_wait_done;
    push_cmd.addr      = cmd_addr;
    push_cmd.wdata     = cmd_wdata;
  end

  ecc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .wdata (push_cmd),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign capture   = (state == ACCESS) && !PWRITE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // ACCESS and a finished WAIT_DONE share one exit: chain straight into the
  // next SETUP when work is queued so PSEL never drops between transfers.
  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    leave       = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP:  next_state = ACCESS;
      ACCESS: begin
        if (PWRITE && cur_wait_done) next_state = WAIT_DONE;
        else                         leave      = 1'b1;
      end
      WAIT_DONE: begin
        if (operation_done)            done_hit    = 1'b1;
        else if (wait_cnt == CNT_LAST) timeout_hit = 1'b1;
        leave = done_hit || timeout_hit;
      end
      default: next_state = IDLE;
    endcase
    if (leave) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        next_state = SETUP;
      end else begin
        next_state = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PSEL          <= 1'b0;
      PENABLE       <= 1'b0;
      PWRITE        <= 1'b0;
      PADDR         <= '0;
      PWDATA        <= '0;
      cur_wait_done <= 1'b0;
    end else begin
      PSEL    <= (next_state == SETUP) || (next_state == ACCESS);
      PENABLE <= (next_state == ACCESS);
      if (pop) begin
        PADDR         <= head.addr;
        PWDATA        <= head.wdata;
        PWRITE        <= head.write;
        cur_wait_done <= head.wait_done;
      end
    end
  end

  // A timeout raised in the same cycle as err_clr must stay visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      rsp_valid  <= capture;
      done_pulse <= done_hit;
      if (capture)          rsp_rdata   <= PRDATA;
      if (timeout_hit)      timeout_err <= 1'b1;
      else if (err_clr)     timeout_err <= 1'b0;
      if (state == WAIT_DONE) wait_cnt <= wait_cnt + CNT_W'(1);
      else                    wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ecc_apb_requester.sv
// Bench for ecc_apb_requester: table vectors, directed multi-cycle sequences
// and a randomized run scored against a transaction-level reference model.
module tb_ecc_apb_requester;

  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int DT    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic          cmd_wait_done;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          done_pulse;
  logic          timeout_err;
  logic          err_clr;
  logic          busy;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PRDATA;
  logic          operation_done;

  always #5 clk = ~clk;

  ecc_apb_requester #(
    .AMBA_ADDR_WIDTH (AW),
    .AMBA_WORD       (DW),
    .FIFO_DEPTH      (DEPTH),
    .DONE_TIMEOUT    (DT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_wait_done  (cmd_wait_done),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .done_pulse     (done_pulse),
    .timeout_err    (timeout_err),
    .err_clr        (err_clr),
    .busy           (busy),
    .PADDR          (PADDR),
    .PWDATA         (PWDATA),
    .PSEL           (PSEL),
    .PENABLE        (PENABLE),
    .PWRITE         (PWRITE),
    .PRDATA         (PRDATA),
    .operation_done (operation_done)
  );

  typedef struct packed {
    logic          write;
    logic          wait_done;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_rec_t;

  typedef struct packed {
    cmd_rec_t      cmd;
    logic [DW-1:0] prdata;
    logic [AW-1:0] exp_paddr;
    logic          exp_pwrite;
    logic [DW-1:0] exp_pwdata;
    logic          exp_rsp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted commands, expected pulses and the
  // number of cycles spent waiting for operation_done.
  cmd_rec_t      exp_q[$];
  cmd_rec_t      cur_cmd;
  bit            matched;
  bit            exp_rsp;
  logic [DW-1:0] exp_rsp_data;
  bit            exp_done;
  bit            model_terr;
  bit            in_wait;
  int            wait_idx;
  bit            prev_setup;
  logic [AW-1:0] setup_addr;
  logic          setup_write;
  logic [DW-1:0] setup_wdata;
  int            done_seen;
  int            rsp_seen;

  bit            s_valid;
  cmd_rec_t      s_cmd;
  int            done_at_idx = -1;
  bit            rand_done;
  bit            s_clr;
  bit            clr_on_last;
  bit            use_fix;
  logic [DW-1:0] fix_prdata;
  bit            accepted;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_rsp    = 1'b0;
    exp_done   = 1'b0;
    model_terr = 1'b0;
    in_wait    = 1'b0;
    wait_idx   = 0;
    prev_setup = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, drive the next inputs,
  // then advance the model to what the following cycle must show.
  task automatic apply_stimulus();
    bit done_now;
    bit timeout_now;
    @(negedge clk);
    check_output("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp) check_output("rsp_rdata", rsp_rdata, exp_rsp_data);
    check_output("done_pulse", done_pulse, exp_done);
    check_output("timeout_err", timeout_err, model_terr);
    if (rsp_valid)  rsp_seen++;
    if (done_pulse) done_seen++;
    if (PENABLE) check_output("penable_needs_psel", PSEL, 1);
    if (in_wait) check_output("apb_idle_in_wait", {PSEL, PENABLE}, 2'b00);
    matched = 1'b0;
    if (PSEL && PENABLE) begin
      check_output("setup_before_access", prev_setup, 1);
      check_output("access_stable", {PADDR, PWRITE, PWDATA}, {setup_addr, setup_write, setup_wdata});
      if (exp_q.size() == 0) begin
        check_output("unexpected_xfer", PENABLE, 0);
      end else begin
        cur_cmd = exp_q.pop_front();
        matched = 1'b1;
        check_output("xfer_addr", PADDR, cur_cmd.addr);
        check_output("xfer_write", PWRITE, cur_cmd.write);
        if (cur_cmd.write) check_output("xfer_wdata", PWDATA, cur_cmd.wdata);
      end
    end
    prev_setup  = PSEL && !PENABLE;
    setup_addr  = PADDR;
    setup_write = PWRITE;
    setup_wdata = PWDATA;

    cmd_valid     = s_valid;
    cmd_write     = s_cmd.write;
    cmd_wait_done = s_cmd.wait_done;
    cmd_addr      = s_cmd.addr;
    cmd_wdata     = s_cmd.wdata;
    if (done_at_idx >= 0) operation_done = in_wait && (wait_idx == done_at_idx);
    else if (rand_done)   operation_done = ($urandom_range(0, 3) == 0);
    else                  operation_done = 1'b0;
    err_clr = s_clr || (clr_on_last && in_wait && (wait_idx == DT - 1));
    PRDATA  = use_fix ? fix_prdata : $urandom();

    exp_rsp      = matched && !cur_cmd.write;
    exp_rsp_data = PRDATA;
    done_now     = in_wait && operation_done;
    timeout_now  = in_wait && !operation_done && (wait_idx == DT - 1);
    exp_done     = done_now;
    if (timeout_now)  model_terr = 1'b1;
    else if (err_clr) model_terr = 1'b0;
    if (in_wait) begin
      if (done_now || timeout_now) in_wait = 1'b0;
      else                         wait_idx++;
    end
    if (matched && cur_cmd.write && cur_cmd.wait_done) begin
      in_wait  = 1'b1;
      wait_idx = 0;
    end
    accepted = cmd_valid && cmd_ready;
    if (accepted) exp_q.push_back(s_cmd);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t     vecs[5];
    cmd_rec_t burst[6];
    int       rejected;
    bit       gap_ok;

    vecs[0] = '{'{1'b1, 1'b0, 20'h00004, 32'hA5A5_0001}, 32'h0000_0000,
                20'h00004, 1'b1, 32'hA5A5_0001, 1'b0, 32'h0000_0000};
    vecs[1] = '{'{1'b0, 1'b0, 20'h0000C, 32'h0000_0000}, 32'h1234_5678,
                20'h0000C, 1'b0, 32'h0000_0000, 1'b1, 32'h1234_5678};
    vecs[2] = '{'{1'b0, 1'b1, 20'hFFFFF, 32'h5555_5555}, 32'hDEAD_BEEF,
                20'hFFFFF, 1'b0, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{'{1'b1, 1'b0, 20'h00000, 32'hFFFF_FFFF}, 32'h0BAD_0BAD,
                20'h00000, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF};
    vecs[4] = '{'{1'b0, 1'b0, 20'h80000, 32'h0000_0000}, 32'hCAFE_F00D,
                20'h80000, 1'b0, 32'h0000_0000, 1'b1, 32'hCAFE_F00D};

    rst            = 1'b0;
    cmd_valid      = 1'b1;
    cmd_write      = 1'b1;
    cmd_wait_done  = 1'b0;
    cmd_addr       = 20'h00040;
    cmd_wdata      = 32'h1111_2222;
    err_clr        = 1'b0;
    PRDATA         = '0;
    operation_done = 1'b0;
    s_cmd          = '0;
    repeat (3) @(negedge clk);
    check_output("rst_apb_ctrl", {PSEL, PENABLE, PWRITE}, 3'b000);
    check_output("rst_apb_bus", {PADDR, PWDATA}, '0);
    check_output("rst_cmd_ready", cmd_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_rsp", {rsp_valid, rsp_rdata}, '0);
    check_output("rst_flags", {done_pulse, timeout_err}, 2'b00);
    cmd_valid = 1'b0;
    rst       = 1'b1;
    model_reset();
    repeat (3) apply_stimulus();
    check_output("rst_no_push", busy, 0);
    check_output("idle_psel", PSEL, 0);

    use_fix = 1'b1;
    foreach (vecs[i]) begin
      fix_prdata = vecs[i].prdata;
      s_cmd      = vecs[i].cmd;
      s_valid    = 1'b1;
      apply_stimulus();
      s_valid = 1'b0;
      apply_stimulus();
      check_output("tbl_idle_psel", PSEL, 0);
      check_output("tbl_busy_queued", busy, 1);
      apply_stimulus();
      check_output("tbl_setup_ctrl", {PSEL, PENABLE}, 2'b10);
      check_output("tbl_setup_paddr", PADDR, vecs[i].exp_paddr);
      check_output("tbl_setup_pwrite", PWRITE, vecs[i].exp_pwrite);
      if (vecs[i].exp_pwrite) check_output("tbl_setup_pwdata", PWDATA, vecs[i].exp_pwdata);
      apply_stimulus();
      check_output("tbl_access_ctrl", {PSEL, PENABLE}, 2'b11);
      check_output("tbl_access_paddr", PADDR, vecs[i].exp_paddr);
      check_output("tbl_access_pwrite", PWRITE, vecs[i].exp_pwrite);
      if (vecs[i].exp_pwrite) check_output("tbl_access_pwdata", PWDATA, vecs[i].exp_pwdata);
      apply_stimulus();
      check_output("tbl_rsp_valid", rsp_valid, vecs[i].exp_rsp);
      check_output("tbl_rsp_rdata", rsp_rdata, vecs[i].exp_rdata);
      check_output("tbl_psel_released", PSEL, 0);
      apply_stimulus();
      check_output("tbl_rsp_pulse_end", rsp_valid, 0);
      check_output("tbl_busy_done", busy, 0);
    end
    use_fix = 1'b0;

    // Park the FSM in WAIT_DONE so the FIFO fills, then release it.
    burst[0] = '{1'b1, 1'b1, 20'h00010, 32'h0000_0011};
    burst[1] = '{1'b1, 1'b0, 20'h00020, 32'h0000_0022};
    burst[2] = '{1'b0, 1'b0, 20'h00030, 32'h0000_0000};
    burst[3] = '{1'b0, 1'b1, 20'h00040, 32'h0000_0000};
    burst[4] = '{1'b1, 1'b0, 20'h00050, 32'h0000_0055};
    burst[5] = '{1'b0, 1'b0, 20'h00060, 32'h0000_0000};
    done_seen   = 0;
    done_at_idx = 10;
    s_valid     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_cmd = burst[i];
      apply_stimulus();
      check_output("burst_push_accept", accepted, 1);
    end
    s_cmd = burst[5];
    apply_stimulus();
    check_output("fifo_full_ready", cmd_ready, 0);
    rejected = 0;
    while (!accepted && rejected < 40) begin
      rejected++;
      apply_stimulus();
    end
    check_output("full_stall_cycles", rejected, 10);
    s_valid = 1'b0;
    gap_ok  = PSEL;
    repeat (8) begin
      apply_stimulus();
      gap_ok = gap_ok && PSEL;
    end
    check_output("b2b_no_gap", gap_ok, 1);
    repeat (3) apply_stimulus();
    check_output("burst_psel_end", PSEL, 0);
    check_output("burst_drained", exp_q.size(), 0);
    check_output("burst_done_once", done_seen, 1);
    check_output("burst_no_timeout", timeout_err, 0);
    done_at_idx = -1;

    s_cmd     = '{1'b1, 1'b1, 20'h00070, 32'h7777_0000};
    done_seen = 0;
    s_valid   = 1'b1;
    apply_stimulus();
    s_valid = 1'b0;
    repeat (22) apply_stimulus();
    check_output("timeout_set", timeout_err, 1);
    check_output("timeout_no_done", done_seen, 0);

    clr_on_last = 1'b1;
    s_valid     = 1'b1;
    apply_stimulus();
    s_valid = 1'b0;
    repeat (22) apply_stimulus();
    check_output("timeout_set_wins", timeout_err, 1);
    clr_on_last = 1'b0;

    s_clr = 1'b1;
    apply_stimulus();
    s_clr = 1'b0;
    apply_stimulus();
    check_output("err_clr_clears", timeout_err, 0);

    done_at_idx = DT - 1;
    done_seen   = 0;
    s_valid     = 1'b1;
    apply_stimulus();
    s_valid = 1'b0;
    repeat (22) apply_stimulus();
    check_output("done_final_pulse", done_seen, 1);
    check_output("done_final_no_err", timeout_err, 0);
    done_at_idx = -1;

    rand_done = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      s_valid         = ($urandom_range(0, 1) == 1);
      s_cmd.write     = ($urandom_range(0, 1) == 1);
      s_cmd.wait_done = ($urandom_range(0, 3) == 0);
      s_cmd.addr      = AW'($urandom());
      s_cmd.wdata     = $urandom();
      s_clr           = ($urandom_range(0, 31) == 0);
      apply_stimulus();
    end
    s_valid = 1'b0;
    s_clr   = 1'b0;
    for (int n = 0; n < 400 && (exp_q.size() != 0 || in_wait); n++) apply_stimulus();
    repeat (3) apply_stimulus();
    check_output("random_drained", exp_q.size(), 0);
    check_output("random_idle", busy, 0);
    rand_done = 1'b0;

    // Reset in the ACCESS phase of a read with three commands still queued.
    burst[0] = '{1'b1, 1'b0, 20'h00100, 32'h0000_0100};
    burst[1] = '{1'b0, 1'b0, 20'h00104, 32'h0000_0000};
    burst[2] = '{1'b1, 1'b0, 20'h00108, 32'h0000_0108};
    burst[3] = '{1'b0, 1'b0, 20'h0010C, 32'h0000_0000};
    burst[4] = '{1'b1, 1'b0, 20'h00110, 32'h0000_0110};
    s_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_cmd = burst[i];
      apply_stimulus();
    end
    s_valid = 1'b0;
    apply_stimulus();
    check_output("mid_access_ctrl", {PSEL, PENABLE, PWRITE}, 3'b110);
    check_output("mid_access_queued", exp_q.size(), 3);
    rst = 1'b0;
    #1;
    check_output("abort_apb_ctrl", {PSEL, PENABLE}, 2'b00);
    check_output("abort_fifo_empty", {busy, cmd_ready}, 2'b01);
    model_reset();
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    rsp_seen = 0;
    repeat (8) apply_stimulus();
    check_output("abort_no_rsp", rsp_seen, 0);
    check_output("abort_stays_idle", {busy, PSEL}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
